// File: rtl/cache_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : cache_controller
// Brief   : Direct-mapped, write-through, no-write-allocate data-cache sequencer.
//           Owns tag/valid arrays, sequences block fills and store-through writes.
// Revision: 1.0
// -----------------------------------------------------------------------------
module cache_controller #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        MemReadCpu,
  input  logic                        MemWriteCpu,
  input  logic [ADDR_W-1:0]           Address,
  input  logic [DATA_W-1:0]           DataIn,
  output logic                        Stall,
  output logic                        Hit,
  output logic                        MemRdReq,
  output logic                        MemWrReq,
  output logic [ADDR_W-1:0]           MemAddr,
  output logic [DATA_W-1:0]           MemWData,
  input  logic                        MemAck,
  input  logic [DATA_W-1:0]           MemRData,
  output logic                        CacheWE,
  output logic [INDEX_W+OFFSET_W-1:0] CacheWAddr,
  output logic [DATA_W-1:0]           CacheWData
);

  localparam int LINES = 1 << INDEX_W;
  localparam logic [OFFSET_W-1:0] c_last_beat = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic [OFFSET_W-1:0] r_beat;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag [LINES];
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic [TAG_W-1:0]    w_cpu_tag;
  logic [INDEX_W-1:0]  w_cpu_index;
  logic [TAG_W-1:0]    w_lat_tag;
  logic [INDEX_W-1:0]  w_lat_index;
  logic                w_lat_hit;

  assign w_cpu_tag   = Address[ADDR_W-1 -: TAG_W];
  assign w_cpu_index = Address[OFFSET_W +: INDEX_W];
  assign w_lat_tag   = r_addr[ADDR_W-1 -: TAG_W];
  assign w_lat_index = r_addr[OFFSET_W +: INDEX_W];

  assign Hit       = r_valid[w_cpu_index] && (r_tag[w_cpu_index] == w_cpu_tag);
  // A store only updates the data array if its block is resident (no allocate).
  assign w_lat_hit = r_valid[w_lat_index] && (r_tag[w_lat_index] == w_lat_tag);

  always_comb begin
    Stall      = 1'b0;
    MemRdReq   = 1'b0;
    MemWrReq   = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    CacheWE    = 1'b0;
    CacheWAddr = '0;
    CacheWData = '0;
    case (r_state)
      IDLE: begin
        Stall = MemWriteCpu | (MemReadCpu & ~Hit);
      end
      FILL: begin
        Stall    = 1'b1;
        MemRdReq = 1'b1;
        MemAddr  = {w_lat_tag, w_lat_index, r_beat};
        if (MemAck) begin
          CacheWE    = 1'b1;
          CacheWAddr = {w_lat_index, r_beat};
          CacheWData = MemRData;
        end
      end
      WRITE: begin
        // Releasing Stall in the ack cycle lets the PC advance on that edge.
        Stall    = ~MemAck;
        MemWrReq = 1'b1;
        MemAddr  = r_addr;
        MemWData = r_data;
        if (MemAck && w_lat_hit) begin
          CacheWE    = 1'b1;
          CacheWAddr = r_addr[INDEX_W+OFFSET_W-1:0];
          CacheWData = r_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_valid <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (MemWriteCpu) begin
            r_addr  <= Address;
            r_data  <= DataIn;
            r_state <= WRITE;
          end else if (MemReadCpu && !Hit) begin
            r_addr  <= Address;
            r_beat  <= '0;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (MemAck) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_last_beat) begin
              r_tag[w_lat_index]   <= w_lat_tag;
              r_valid[w_lat_index] <= 1'b1;
              r_beat               <= '0;
              r_state              <= IDLE;
            end
          end
        end
        WRITE: begin
          if (MemAck) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : tb_cache_controller
// Brief   : Directed self-checking bench for cache_controller with a tag/valid model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_cache_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemReadCpu, MemWriteCpu, MemAck;
  logic [9:0]  Address;
  logic [31:0] DataIn, MemRData;
  logic        Stall, Hit, MemRdReq, MemWrReq, CacheWE;
  logic [9:0]  MemAddr;
  logic [31:0] MemWData, CacheWData;
  logic [6:0]  CacheWAddr;

  always #5 CLK = ~CLK;

  cache_controller dut (
    .CLK(CLK), .RST(RST), .MemReadCpu(MemReadCpu), .MemWriteCpu(MemWriteCpu),
    .Address(Address), .DataIn(DataIn), .Stall(Stall), .Hit(Hit),
    .MemRdReq(MemRdReq), .MemWrReq(MemWrReq), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData), .CacheWE(CacheWE), .CacheWAddr(CacheWAddr),
    .CacheWData(CacheWData)
  );

  int checks = 0;
  int errors = 0;

  // Reference cache directory: what must be resident according to the policy.
  logic       m_valid [32];
  logic [2:0] m_tag   [32];

  logic        chk_en = 1'b0;
  logic        e_stall, e_hit, e_rdreq, e_wrreq, e_we;
  logic [9:0]  e_maddr;
  logic [31:0] e_mwdata, e_wdata;
  logic [6:0]  e_waddr;

  int          n_stall, n_we, n_rdreq, n_wrreq;
  logic [9:0]  q_fa[$];
  logic [6:0]  q_wa[$];
  logic [31:0] last_we_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [9:0] a);
    return m_valid[a[6:2]] && (m_tag[a[6:2]] == a[9:7]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  task automatic expect_cyc(input logic st, input logic rd, input logic wr, input logic we,
                            input logic [9:0] ma, input logic [31:0] md,
                            input logic [6:0] wa, input logic [31:0] wd);
    e_stall = st; e_rdreq = rd; e_wrreq = wr; e_we = we;
    e_maddr = ma; e_mwdata = md; e_waddr = wa; e_wdata = wd;
    e_hit   = m_hit(Address);
  endtask

  task automatic clr_counters();
    n_stall = 0; n_we = 0; n_rdreq = 0; n_wrreq = 0;
    q_fa.delete(); q_wa.delete();
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("stall", Stall, e_stall);
      chk("hit", Hit, e_hit);
      chk("mem_rd_req", MemRdReq, e_rdreq);
      chk("mem_wr_req", MemWrReq, e_wrreq);
      chk("cache_we", CacheWE, e_we);
      if (e_rdreq || e_wrreq) chk("mem_addr", MemAddr, e_maddr);
      if (e_wrreq) chk("mem_wdata", MemWData, e_mwdata);
      if (e_we) begin
        chk("cache_waddr", CacheWAddr, e_waddr);
        chk("cache_wdata", CacheWData, e_wdata);
      end
      n_stall += int'(Stall);
      n_we    += int'(CacheWE);
      n_rdreq += int'(MemRdReq);
      n_wrreq += int'(MemWrReq);
      if (MemRdReq && MemAck) q_fa.push_back(MemAddr);
      if (CacheWE) begin
        q_wa.push_back(CacheWAddr);
        last_we_data = CacheWData;
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle(input logic [9:0] a, input logic ack);
    next_cycle();
    MemReadCpu = 1'b0; MemWriteCpu = 1'b0; Address = a; MemAck = ack;
    expect_cyc(0, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);
  endtask

  // Load: a miss fetches the whole block (beats 0..3), then the held read hits.
  task automatic do_read(input logic [9:0] a, input logic [31:0] base, input int gap);
    logic h;
    logic [9:0] ba;
    next_cycle();
    MemReadCpu = 1'b1; MemWriteCpu = 1'b0; Address = a; MemAck = 1'b0;
    h = m_hit(a);
    expect_cyc(!h, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);
    if (!h) begin
      for (int b = 0; b < 4; b++) begin
        ba = {a[9:2], 2'b00} + 10'(b);
        for (int g = 0; g < gap; g++) begin
          next_cycle();
          MemAck = 1'b0;
          expect_cyc(1, 1, 0, 0, ba, 32'h0, 7'h0, 32'h0);
        end
        next_cycle();
        MemAck = 1'b1; MemRData = base + 32'(b);
        expect_cyc(1, 1, 0, 1, ba, 32'h0, ba[6:0], base + 32'(b));
      end
      next_cycle();
      MemAck = 1'b0;
      m_valid[a[6:2]] = 1'b1;
      m_tag[a[6:2]]   = a[9:7];
      expect_cyc(0, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);
    end
  endtask

  // Store-through: CPU inputs are scrambled while waiting to prove they are latched.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int waits);
    logic h;
    next_cycle();
    MemWriteCpu = 1'b1; MemReadCpu = 1'b0; Address = a; DataIn = d; MemAck = 1'b0;
    h = m_hit(a);
    expect_cyc(1, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);
    for (int w = 0; w < waits; w++) begin
      next_cycle();
      Address = ~a; DataIn = ~d; MemReadCpu = 1'b1;
      expect_cyc(1, 0, 1, 0, a, d, 7'h0, 32'h0);
    end
    next_cycle();
    MemAck = 1'b1;
    expect_cyc(0, 0, 1, h, a, d, a[6:0], d);
    idle_cycle(a, 1'b0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    RST = 1'b1; MemReadCpu = 1'b0; MemWriteCpu = 1'b0; MemAck = 1'b0;
    Address = 10'h0; DataIn = 32'h0; MemRData = 32'h0;
    model_clear();
    clr_counters();
    next_cycle();
    chk("rst_stall", Stall, 0);
    chk("rst_rdreq", MemRdReq, 0);
    chk("rst_wrreq", MemWrReq, 0);
    chk("rst_we", CacheWE, 0);
    chk("rst_maddr", MemAddr, 0);
    chk("rst_mwdata", MemWData, 0);
    next_cycle();
    RST = 1'b0;
    chk_en = 1'b1;
    expect_cyc(0, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);

    // Cold miss on 0x005 with back-to-back acks
    clr_counters();
    do_read(10'h005, 32'hA0, 0);
    chk("fill1_stall_cycles", n_stall, 5);
    chk("fill1_we_pulses", n_we, 4);
    chk("fill1_first_addr", q_fa[0], 10'h004);
    chk("fill1_last_addr", q_fa[3], 10'h007);
    chk("fill1_first_waddr", q_wa[0], 7'h04);
    chk("fill1_last_waddr", q_wa[3], 7'h07);
    chk("fill1_hit_after", Hit, 1);
    chk("fill1_stall_after", Stall, 0);

    // Same-block read hits with no memory traffic
    clr_counters();
    do_read(10'h006, 32'h0, 0);
    chk("hit006_hit", Hit, 1);
    chk("hit006_stall", Stall, 0);
    idle_cycle(10'h006, 1'b0);
    chk("hit006_no_rdreq", n_rdreq, 0);

    // Store hit, ack on the third request cycle
    clr_counters();
    do_write(10'h006, 32'hDEADBEEF, 2);
    chk("st_hit_wrreq_cycles", n_wrreq, 3);
    chk("st_hit_we_pulses", n_we, 1);
    chk("st_hit_waddr", q_wa[0], 7'h06);
    chk("st_hit_wdata", last_we_data, 32'hDEADBEEF);

    // Store miss: no allocate, so 0x085 still misses afterwards
    clr_counters();
    do_write(10'h085, 32'h12345678, 1);
    chk("st_miss_we_pulses", n_we, 0);
    idle_cycle(10'h085, 1'b1);
    chk("st_miss_read_hit", Hit, 0);

    // Conflict miss: 0x084 evicts block 0x004, then 0x004 misses again
    clr_counters();
    do_read(10'h084, 32'hC0, 1);
    chk("conflict_first_addr", q_fa[0], 10'h084);
    chk("conflict_last_addr", q_fa[3], 10'h087);
    clr_counters();
    do_read(10'h004, 32'hD0, 0);
    chk("reread004_rdreq", n_rdreq, 4);

    // Reset in the middle of a fill of 0x105
    next_cycle();
    MemReadCpu = 1'b1; Address = 10'h105; MemAck = 1'b0;
    expect_cyc(1, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      MemAck = 1'b1; MemRData = 32'hE0 + 32'(b);
      expect_cyc(1, 1, 0, 1, 10'h104 + 10'(b), 32'h0, 7'h04 + 7'(b), 32'hE0 + 32'(b));
    end
    next_cycle();
    chk_en = 1'b0;
    MemAck = 1'b0; MemReadCpu = 1'b0; RST = 1'b1;
    #1;
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_rdreq", MemRdReq, 0);
    chk("mid_rst_wrreq", MemWrReq, 0);
    chk("mid_rst_we", CacheWE, 0);
    chk("mid_rst_maddr", MemAddr, 0);
    chk("mid_rst_mwdata", MemWData, 0);
    chk("mid_rst_hit", Hit, 0);
    model_clear();
    next_cycle();
    RST = 1'b0;
    chk_en = 1'b1;
    expect_cyc(0, 0, 0, 0, 10'h0, 32'h0, 7'h0, 32'h0);

    clr_counters();
    do_read(10'h005, 32'hF0, 0);
    chk("post_rst_rdreq", n_rdreq, 4);
    chk("post_rst_first_addr", q_fa[0], 10'h004);
    idle_cycle(10'h005, 1'b0);
    next_cycle();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
